// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, FSM state types and the fixed ARP header bytes.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
    localparam logic [15:0] ARP_OPER_REP   = 16'd2;
    localparam int          ARP_LEN        = 28;

    typedef enum logic {R_IDLE, R_ARP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_DATA, T_DONE} tx_state_t;

    // htype, ptype, hlen, plen: the first six bytes every Ethernet/IPv4 ARP packet carries
    function automatic logic [7:0] arp_hdr_byte(input logic [2:0] idx);
        logic [47:0] hdr;
        hdr = {ARP_HTYPE_ETH, ETHERTYPE_IPV4, 8'd6, 8'd4};
        return hdr[8*(5-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/arp_responder_parse.sv
// RX side: walks an ARP payload byte by byte, captures sender fields into shadow
// registers and raises a combinational accept in the rx_frameend cycle.
module arp_parse
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip,
    input  logic [7:0]  rx_data,
    input  logic        rx_dven,
    input  logic        rx_newframehead,
    input  logic [15:0] rx_ethertype,
    input  logic        rx_frameend,
    input  logic        rx_err,
    output logic        accept,
    output logic [47:0] sha,
    output logic [31:0] spa
);

    localparam logic [4:0] LEN5 = 5'(ARP_LEN);

    rx_state_t   state;
    logic [4:0]  idx;
    logic        bad;
    logic [15:0] oper;
    logic [31:0] tpa;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= R_IDLE;
            idx   <= '0;
            bad   <= 1'b0;
            oper  <= '0;
            sha   <= '0;
            spa   <= '0;
            tpa   <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (rx_newframehead && rx_ethertype == ETHERTYPE_ARP) begin
                        state <= R_ARP;
                        idx   <= '0;
                        bad   <= 1'b0;
                    end
                end
                R_ARP: begin
                    // a new header without a frameend means the old frame is lost
                    if (rx_newframehead) begin
                        idx <= '0;
                        bad <= 1'b0;
                        if (rx_ethertype != ETHERTYPE_ARP)
                            state <= R_IDLE;
                    end else if (rx_frameend) begin
                        state <= R_IDLE;
                    end else if (rx_dven && idx < LEN5) begin
                        idx <= idx + 5'd1;
                        if (idx < 5'd6 && rx_data != arp_hdr_byte(idx[2:0]))
                            bad <= 1'b1;
                        if (idx >= 5'd6 && idx <= 5'd7)
                            oper <= {oper[7:0], rx_data};
                        if (idx >= 5'd8 && idx <= 5'd13)
                            sha <= {sha[39:0], rx_data};
                        if (idx >= 5'd14 && idx <= 5'd17)
                            spa <= {spa[23:0], rx_data};
                        if (idx >= 5'd24)
                            tpa <= {tpa[23:0], rx_data};
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    assign accept = (state == R_ARP) && rx_frameend && !rx_newframehead &&
                    (idx == LEN5) && !bad && (oper == ARP_OPER_REQ) &&
                    (tpa == ip) && !rx_err;

endmodule

// File: rtl/arp_responder.sv
// ARP responder: TX FSM, reply byte mux and statistics. Counters are built only
// when ARP_STATS_EN is defined; otherwise cnt_* read as zero.
module arp_responder
    import eth_pkg::*;
#(
    parameter int DROPW   = 16,
    parameter int ACKWAIT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [47:0]      mac,
    input  logic [31:0]      ip,
    input  logic [7:0]       rx_data,
    input  logic             rx_dven,
    input  logic             rx_newframehead,
    input  logic [15:0]      rx_ethertype,
    input  logic [47:0]      rx_smac,
    input  logic             rx_frameend,
    input  logic             rx_err,
    output logic             tx_request,
    input  logic             tx_ack,
    input  logic             tx_busy,
    output logic             tx_dven,
    output logic [7:0]       tx_data,
    output logic [47:0]      tx_dmac,
    output logic [47:0]      tx_smac,
    output logic [15:0]      tx_ethertype,
    output logic [DROPW-1:0] cnt_req,
    output logic [DROPW-1:0] cnt_rep,
    output logic [DROPW-1:0] cnt_drop
);

    localparam int         WW   = $clog2(ACKWAIT + 1) + 1;
    localparam logic [4:0] LEN5 = 5'(ARP_LEN);

    logic        accept;
    logic [47:0] sha_c;
    logic [31:0] spa_c;

    // sender MAC is taken from the ARP body, so the Ethernet header copy is not needed
    logic unused_smac;
    assign unused_smac = ^rx_smac;

    arp_parse u_parse (
        .clk             (clk),
        .reset           (reset),
        .ip              (ip),
        .rx_data         (rx_data),
        .rx_dven         (rx_dven),
        .rx_newframehead (rx_newframehead),
        .rx_ethertype    (rx_ethertype),
        .rx_frameend     (rx_frameend),
        .rx_err          (rx_err),
        .accept          (accept),
        .sha             (sha_c),
        .spa             (spa_c)
    );

    tx_state_t     tstate;
    logic [47:0]   tha;
    logic [31:0]   tpa_r;
    logic [4:0]    k;
    logic [WW-1:0] wait_cnt;
    logic [223:0]  reply;
    logic [4:0]    k_sel;
    logic [7:0]    reply_byte;

    assign reply = {ARP_HTYPE_ETH, ETHERTYPE_IPV4, 8'd6, 8'd4, ARP_OPER_REP, mac, ip, tha, tpa_r};

    always_comb begin
        k_sel      = (k < LEN5) ? k : 5'd0;
        reply_byte = reply[8*(ARP_LEN-1-int'(k_sel)) +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tstate       <= T_IDLE;
            tha          <= '0;
            tpa_r        <= '0;
            k            <= '0;
            wait_cnt     <= '0;
            tx_request   <= 1'b0;
            tx_dven      <= 1'b0;
            tx_data      <= '0;
            tx_dmac      <= '0;
            tx_smac      <= '0;
            tx_ethertype <= '0;
        end else begin
            case (tstate)
                T_IDLE: begin
                    // shadow fields commit only here, so a pending reply is never disturbed
                    if (accept) begin
                        tha          <= sha_c;
                        tpa_r        <= spa_c;
                        tx_dmac      <= sha_c;
                        tx_smac      <= mac;
                        tx_ethertype <= ETHERTYPE_ARP;
                        tx_request   <= 1'b1;
                        wait_cnt     <= '0;
                        k            <= '0;
                        tstate       <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (tx_ack) begin
                        tx_request <= 1'b0;
                        tx_dven    <= 1'b1;
                        tx_data    <= reply_byte;
                        k          <= 5'd1;
                        tstate     <= T_DATA;
                    end else if (wait_cnt == WW'(ACKWAIT)) begin
                        tx_request <= 1'b0;
                        tstate     <= T_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (k == LEN5) begin
                        tx_dven <= 1'b0;
                        tx_data <= '0;
                        tstate  <= T_DONE;
                    end else begin
                        tx_data <= reply_byte;
                        k       <= k + 5'd1;
                    end
                end
                T_DONE: begin
                    if (!tx_busy)
                        tstate <= T_IDLE;
                end
                default: tstate <= T_IDLE;
            endcase
        end
    end

`ifdef ARP_STATS_EN
    logic drop_ev, rep_ev;
    assign drop_ev = (accept && tstate != T_IDLE) ||
                     (tstate == T_REQ && !tx_ack && wait_cnt == WW'(ACKWAIT));
    assign rep_ev  = (tstate == T_DONE) && !tx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_req  <= '0;
            cnt_rep  <= '0;
            cnt_drop <= '0;
        end else begin
            if (accept && cnt_req != '1)   cnt_req  <= cnt_req + 1'b1;
            if (rep_ev && cnt_rep != '1)   cnt_rep  <= cnt_rep + 1'b1;
            if (drop_ev && cnt_drop != '1) cnt_drop <= cnt_drop + 1'b1;
        end
    end
`else
    assign cnt_req  = '0;
    assign cnt_rep  = '0;
    assign cnt_drop = '0;
`endif

endmodule

// File: tb/tb_arp_responder.sv
// Directed bench for arp_responder with a frame-level reference model and a per-cycle output monitor.
module tb_arp_responder;

    localparam int          ACKW = 40;
    localparam logic [47:0] MAC  = 48'h0A1B2C3D4E5F;
    localparam logic [31:0] IP   = 32'h0A000002;
    localparam logic [223:0] LIT1 =
        224'h0001_0800_0604_0002_0A1B2C3D4E5F_0A000002_020000000001_0A000001;

    logic        clk, reset;
    logic [7:0]  rx_data;
    logic        rx_dven, rx_newframehead, rx_frameend, rx_err;
    logic [15:0] rx_ethertype;
    logic [47:0] rx_smac;
    logic        tx_request, tx_ack, tx_busy, tx_dven;
    logic [7:0]  tx_data;
    logic [47:0] tx_dmac, tx_smac;
    logic [15:0] tx_ethertype;
    logic [15:0] cnt_req, cnt_rep, cnt_drop;

    arp_responder #(.DROPW(16), .ACKWAIT(ACKW)) dut (
        .clk(clk), .reset(reset), .mac(MAC), .ip(IP),
        .rx_data(rx_data), .rx_dven(rx_dven), .rx_newframehead(rx_newframehead),
        .rx_ethertype(rx_ethertype), .rx_smac(rx_smac), .rx_frameend(rx_frameend),
        .rx_err(rx_err), .tx_request(tx_request), .tx_ack(tx_ack), .tx_busy(tx_busy),
        .tx_dven(tx_dven), .tx_data(tx_data), .tx_dmac(tx_dmac), .tx_smac(tx_smac),
        .tx_ethertype(tx_ethertype), .cnt_req(cnt_req), .cnt_rep(cnt_rep), .cnt_drop(cnt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: one reply slot, statistics as the MAC host would tally them
    bit           armed = 1'b0;
    bit           m_pending = 1'b0;
    logic [223:0] exp_reply = '0;
    logic [47:0]  exp_dmac = '0;
    int           m_req = 0, m_rep = 0, m_drop = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [223:0] mk(input logic [15:0] oper, input logic [15:0] ptype,
                                        input logic [47:0] sha, input logic [31:0] spa,
                                        input logic [31:0] tpa);
        return {16'h0001, ptype, 8'h06, 8'h04, oper, sha, spa, 48'h0, tpa};
    endfunction

    function automatic bit model_accept(input logic [223:0] f, input int n, input bit err,
                                        input logic [15:0] et);
        return (et == 16'h0806) && (n >= 28) && !err &&
               (f[223:208] == 16'h0001) && (f[207:192] == 16'h0800) &&
               (f[191:184] == 8'h06) && (f[183:176] == 8'h04) &&
               (f[175:160] == 16'h0001) && (f[31:0] == IP);
    endfunction

    function automatic logic [223:0] model_reply(input logic [223:0] f);
        return {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, MAC, IP, f[159:112], f[111:80]};
    endfunction

    // per-cycle monitor: quiet when nothing is owed, reply bytes and header when active
    int pos = 0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            pos = 0;
        end else begin
            if (!armed)
                chk("idle_quiet", {tx_request, tx_dven}, 2'b00);
            if (tx_dven) begin
                if (pos < 28)
                    chk("reply_byte", tx_data, exp_reply[8*(27-pos) +: 8]);
                else
                    chk("burst_overrun", pos, 27);
                pos++;
            end else begin
                pos = 0;
            end
            if (tx_request || tx_dven) begin
                chk("hdr_dmac", tx_dmac, exp_dmac);
                chk("hdr_smac", tx_smac, MAC);
                chk("hdr_etype", tx_ethertype, 16'h0806);
            end
        end
    end

    task automatic check_counts(input string tag);
`ifdef ARP_STATS_EN
        chk({tag, "_cnt_req"}, cnt_req, m_req);
        chk({tag, "_cnt_rep"}, cnt_rep, m_rep);
        chk({tag, "_cnt_drop"}, cnt_drop, m_drop);
`else
        chk({tag, "_cnt_req"}, cnt_req, 0);
        chk({tag, "_cnt_rep"}, cnt_rep, 0);
        chk({tag, "_cnt_drop"}, cnt_drop, 0);
`endif
    endtask

    task automatic send_frame(input logic [223:0] f, input int n, input bit err,
                              input logic [15:0] et);
        bit acc, newreq;
        @(negedge clk);
        rx_newframehead = 1'b1;
        rx_ethertype    = et;
        rx_smac         = f[159:112];
        @(negedge clk);
        rx_newframehead = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx_dven = 1'b1;
            if (i < 28) rx_data = f[8*(27-i) +: 8];
            else        rx_data = 8'h00;
            @(negedge clk);
        end
        rx_dven     = 1'b0;
        rx_data     = 8'h00;
        rx_frameend = 1'b1;
        rx_err      = err;
        acc    = model_accept(f, n, err, et);
        newreq = acc && !m_pending;
        if (acc) begin
            m_req++;
            if (m_pending) m_drop++;
            else begin
                m_pending = 1'b1;
                armed     = 1'b1;
                exp_reply = model_reply(f);
                exp_dmac  = f[159:112];
            end
        end
        @(posedge clk);
        #1;
        chk("req_latency", tx_request, newreq);
        @(negedge clk);
        rx_frameend = 1'b0;
        rx_err      = 1'b0;
    endtask

    // plays the MAC: grant, collect the burst, hold busy through a gap
    task automatic serve(output logic [223:0] got);
        int w, cnt;
        got = '0;
        w = 0;
        while (!tx_request && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_seen", tx_request, 1);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        chk("ack_latency", tx_dven, 1);
        tx_busy = 1'b1;
        cnt = 0;
        while (tx_dven && cnt < 40) begin
            if (cnt < 28) got[8*(27-cnt) +: 8] = tx_data;
            cnt++;
            @(negedge clk);
        end
        chk("burst_len", cnt, 28);
        repeat (4) @(negedge clk);
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        m_rep++;
        m_pending = 1'b0;
        armed     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [223:0] got, f1, f2;
        int cnt;
        reset = 1'b1;
        rx_data = '0; rx_dven = 0; rx_newframehead = 0; rx_ethertype = '0;
        rx_smac = '0; rx_frameend = 0; rx_err = 0; tx_ack = 0; tx_busy = 0;
        repeat (3) @(negedge clk);
        chk("rst_request", tx_request, 0);
        chk("rst_dven", tx_dven, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_dmac", tx_dmac, 0);
        chk("rst_smac", tx_smac, 0);
        chk("rst_etype", tx_ethertype, 0);
        check_counts("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: basic request, literal reply
        f1 = mk(16'd1, 16'h0800, 48'h020000000001, 32'h0A000001, IP);
        send_frame(f1, 28, 1'b0, 16'h0806);
        chk("t1_dmac_literal", tx_dmac, 48'h020000000001);
        serve(got);
        chk("t1_reply_literal", got, LIT1);
        check_counts("t1");

        // 2: rejected variants and a non-ARP frame
        send_frame(f1, 28, 1'b1, 16'h0806);
        send_frame(mk(16'd1, 16'h0800, 48'h020000000001, 32'h0A000001, 32'h0A000009), 28, 1'b0, 16'h0806);
        send_frame(mk(16'd2, 16'h0800, 48'h020000000001, 32'h0A000001, IP), 28, 1'b0, 16'h0806);
        send_frame(mk(16'd1, 16'h86DD, 48'h020000000001, 32'h0A000001, IP), 28, 1'b0, 16'h0806);
        send_frame(f1, 28, 1'b0, 16'h0800);
        repeat (3) @(negedge clk);
        chk("t2_no_request", tx_request, 0);
        check_counts("t2");

        // 3: truncated frame, then a padded valid one
        send_frame(f1, 20, 1'b0, 16'h0806);
        repeat (3) @(negedge clk);
        chk("t3_trunc_no_request", tx_request, 0);
        f2 = mk(16'd1, 16'h0800, 48'h020000000002, 32'h0A000003, IP);
        send_frame(f2, 46, 1'b0, 16'h0806);
        serve(got);
        chk("t3_reply", got, model_reply(f2));
        chk("t3_reply_tail", got[79:0], 80'h020000000002_0A000003);
        check_counts("t3");

        // 4: second request lands during the first reply's data phase
        send_frame(f1, 28, 1'b0, 16'h0806);
        fork
            begin
                repeat (8) @(negedge clk);
                serve(got);
            end
            send_frame(f2, 28, 1'b0, 16'h0806);
        join
        chk("t4_first_intact", got, LIT1);
        check_counts("t4");

        // 5: ack never comes
        send_frame(f2, 28, 1'b0, 16'h0806);
        cnt = 0;
        while (tx_request && cnt < ACKW + 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("t5_request_cycles", cnt, ACKW + 1);
        m_drop++;
        m_pending = 1'b0;
        armed     = 1'b0;
        repeat (3) @(negedge clk);
        check_counts("t5");
        send_frame(f1, 28, 1'b0, 16'h0806);
        serve(got);
        chk("t5_next_reply", got, LIT1);

        // 6: reset in the middle of a reply
        send_frame(f1, 28, 1'b0, 16'h0806);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_dven", tx_dven, 0);
        chk("t6_request", tx_request, 0);
        chk("t6_data", tx_data, 0);
        chk("t6_dmac", tx_dmac, 0);
        chk("t6_smac", tx_smac, 0);
        chk("t6_etype", tx_ethertype, 0);
        m_req = 0; m_rep = 0; m_drop = 0;
        m_pending = 1'b0;
        armed     = 1'b0;
        check_counts("t6");
        @(negedge clk);
        reset   = 1'b0;
        tx_busy = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_no_resume", tx_dven, 0);
        send_frame(f2, 28, 1'b0, 16'h0806);
        serve(got);
        chk("t6_after_reset_reply", got, model_reply(f2));
        check_counts("t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
